// File: rtl/serial_sub_unit.sv
// rtl/serial_sub_unit.sv - bit-serial subtractor D = A - B - Bi, LSB first, one bit per clock.
// Optional OVF output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  assign w_a        = r_a[0];
  assign w_b        = r_b[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  // Result fills from the MSB end so bit 0 lands at the LSB after WIDTH shifts.
  assign w_res_next = {w_d, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      D       <= '0;
      Bo      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      OVF     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bi;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next[WIDTH-1:1];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            D       <= w_res_next;
            Bo      <= w_br_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            OVF     <= r_br ^ w_br_next;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// tb/tb_serial_sub_unit.sv - randomized self-checking bench for serial_sub_unit against an arithmetic model.
module tb_serial_sub_unit;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bi;
  logic [W-1:0] D;
  logic         Bo;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .D     (D),
    .Bo    (Bo),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_d(input int a, input int b, input int bi);
    return (a - b - bi) & (M - 1);
  endfunction

  function automatic int model_bo(input int a, input int b, input int bi);
    return (a < b + bi) ? 1 : 0;
  endfunction

  function automatic int model_ovf(input int a, input int b, input int bi);
    int sa, sb, r;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    r  = sa - sb - bi;
    return (r < -(M / 2) || r > (M / 2) - 1) ? 1 : 0;
  endfunction

  task automatic start_op(input int a, input int b, input int bi);
    @(negedge clk);
    A = W'(a);
    B = W'(b);
    Bi = 1'(bi);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Waits for done, scrambling inputs and pulsing start while busy; optionally chains the next op.
  task automatic wait_check(input string tag, input int a, input int b, input int bi,
                            input bit chain, input int na, input int nb, input int nbi);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 3 * W && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        n = i;
      end else begin
        check({tag, "_busy"}, busy, 1);
        A = W'($urandom);
        B = W'($urandom);
        Bi = 1'($urandom);
        start = 1'($urandom);
      end
    end
    if (chain) begin
      A = W'(na);
      B = W'(nb);
      Bi = 1'(nbi);
      start = 1'b1;
    end else begin
      start = 1'b0;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_D"}, D, model_d(a, b, bi));
    check({tag, "_Bo"}, Bo, model_bo(a, b, bi));
    check({tag, "_busy_done"}, busy, 0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_OVF"}, OVF, model_ovf(a, b, bi));
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_width"}, done, 0);
    if (chain) begin
      check({tag, "_chain_busy"}, busy, 1);
    end else begin
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_D_hold"}, D, model_d(a, b, bi));
    end
  endtask

  initial begin
    int  a, b, bi, s, ci;
    int  ca, cb, cbi;
    bit  pending, chain, seen;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    Bi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_D", D, 0);
    check("reset_Bo", Bo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    start_op(7, 3, 0);
    wait_check("t1", 7, 3, 0, 1'b0, 0, 0, 0);
    check("t1_const_D", D, 4'b0100);
    check("t1_const_Bo", Bo, 0);

    start_op(3, 5, 0);
    wait_check("t2a", 3, 5, 0, 1'b0, 0, 0, 0);
    check("t2a_const_D", D, 4'b1110);
    check("t2a_const_Bo", Bo, 1);
    start_op(0, 0, 1);
    wait_check("t2b", 0, 0, 1, 1'b0, 0, 0, 0);
    check("t2b_const_D", D, 4'b1111);
    check("t2b_const_Bo", Bo, 1);
    start_op(15, 15, 1);
    wait_check("t2c", 15, 15, 1, 1'b0, 0, 0, 0);
    check("t2c_const_D", D, 4'b1111);
    check("t2c_const_Bo", Bo, 1);

    for (int xa = 0; xa < M; xa++)
      for (int xb = 0; xb < M; xb++)
        for (int xbi = 0; xbi < 2; xbi++) begin
          start_op(xa, xb, xbi);
          wait_check("sweep", xa, xb, xbi, 1'b0, 0, 0, 0);
        end

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(M - 1));
      b = int'($urandom_range(M - 1));
      ci = int'($urandom_range(1));
      s = (a + b + ci) & (M - 1);
      start_op(s, b, ci);
      wait_check("feedback", s, b, ci, 1'b0, 0, 0, 0);
      check("feedback_recovers_A", D, a);
    end

    start_op(5, 9, 1);
    wait_check("b2b1", 5, 9, 1, 1'b1, 12, 3, 0);
    wait_check("b2b2", 12, 3, 0, 1'b0, 0, 0, 0);

    pending = 1'b0;
    ca = 0;
    cb = 0;
    cbi = 0;
    for (int i = 0; i < 150; i++) begin
      if (!pending) begin
        ca = int'($urandom_range(M - 1));
        cb = int'($urandom_range(M - 1));
        cbi = int'($urandom_range(1));
        start_op(ca, cb, cbi);
      end
      a = ca;
      b = cb;
      bi = cbi;
      chain = (i < 149) && ($urandom_range(1) == 1);
      ca = int'($urandom_range(M - 1));
      cb = int'($urandom_range(M - 1));
      cbi = int'($urandom_range(1));
      wait_check("rand", a, b, bi, chain, ca, cb, cbi);
      pending = chain;
    end

    start_op(7, 3, 0);
    wait_check("pre_abort", 7, 3, 0, 1'b0, 0, 0, 0);
    start_op(9, 9, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_D", D, 0);
    check("abort_Bo", Bo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    start_op(9, 1, 0);
    wait_check("after_abort", 9, 1, 0, 1'b0, 0, 0, 0);
    check("after_abort_const_D", D, 4'b1000);
    check("after_abort_const_Bo", Bo, 0);

    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    A = 4'd6;
    B = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", busy, 0);
    @(posedge clk);
    #1;
    check("rst_prio_done", done, 0);

`ifdef SERIAL_SUB_OVF_EN
    start_op(8, 1, 0);
    wait_check("ovf1", 8, 1, 0, 1'b0, 0, 0, 0);
    check("ovf1_const_D", D, 4'b0111);
    check("ovf1_const", OVF, 1);
    start_op(7, 15, 0);
    wait_check("ovf2", 7, 15, 0, 1'b0, 0, 0, 0);
    check("ovf2_const_D", D, 4'b1000);
    check("ovf2_const", OVF, 1);
    start_op(5, 3, 0);
    wait_check("ovf3", 5, 3, 0, 1'b0, 0, 0, 0);
    check("ovf3_const", OVF, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
